// File: rtl/spi_frame_writer.sv
// Frames SPI pixel bytes by chip-select edges and writes them into one half of a
// double-buffered frame BRAM, swapping banks whenever a complete frame has landed.
module spi_frame_writer #(
  parameter int H_PIXELS = 320,
  parameter int V_PIXELS = 180
) (
  input  logic                                   clk_in,
  input  logic                                   rst_n_in,
  input  logic [7:0]                             pixel_in,
  input  logic                                   pixel_valid_in,
  input  logic                                   chip_sel_in,
  output logic [$clog2(H_PIXELS*V_PIXELS):0]     bram_addr_out,
  output logic [7:0]                             bram_data_out,
  output logic                                   bram_we_out,
  output logic                                   read_bank_out,
  output logic                                   frame_done_out,
  output logic                                   frame_error_out,
  output logic [15:0]                            frame_count_out,
  output logic                                   busy_out
);

  localparam int FRAME_SIZE = H_PIXELS * V_PIXELS;
  localparam int PIX_ADDR_W = $clog2(FRAME_SIZE);
  localparam logic [PIX_ADDR_W-1:0] LAST_IDX = PIX_ADDR_W'(FRAME_SIZE - 1);
  localparam logic [PIX_ADDR_W-1:0] ZERO_IDX = {PIX_ADDR_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic                    cs_prev_q;
  logic [PIX_ADDR_W-1:0]   count_q, count_d;
  logic                    ovf_q, ovf_d;
  logic                    bank_q, bank_d;
  logic [PIX_ADDR_W:0]     addr_q, addr_d;
  logic [7:0]              data_q, data_d;
  logic                    we_q, we_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic [15:0]             fcnt_q, fcnt_d;
  logic                    busy_q;
  logic                    fall_s, rise_s;

  assign fall_s = cs_prev_q & ~chip_sel_in;
  assign rise_s = ~cs_prev_q & chip_sel_in;

  // Next-state logic: the pixel is handled before the CS rise in the same cycle.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    bank_d  = bank_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    fcnt_d  = fcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (fall_s) begin
          count_d = ZERO_IDX;
          ovf_d   = 1'b0;
          state_d = ST_RECV;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RECV: begin
        if (fall_s) begin
          count_d = ZERO_IDX;
          ovf_d   = 1'b0;
          state_d = ST_RECV;
        end else begin
          if (pixel_valid_in) begin
            we_d   = 1'b1;
            data_d = pixel_in;
            addr_d = {~bank_q, count_q};
            if (count_q == LAST_IDX) begin
              done_d  = 1'b1;
              bank_d  = ~bank_q;
              fcnt_d  = fcnt_q + 16'd1;
              state_d = ST_DRAIN;
            end else begin
              count_d = count_q + PIX_ADDR_W'(1);
            end
          end else begin
            we_d = 1'b0;
          end
          // A short frame is one whose CS rises before the last pixel arrived.
          if (rise_s) begin
            err_d   = ~done_d;
            state_d = ST_IDLE;
          end else begin
            err_d = 1'b0;
          end
        end
      end
      ST_DRAIN: begin
        if (fall_s) begin
          count_d = ZERO_IDX;
          ovf_d   = 1'b0;
          state_d = ST_RECV;
        end else begin
          if (pixel_valid_in) begin
            ovf_d = 1'b1;
          end else begin
            ovf_d = ovf_q;
          end
          if (rise_s) begin
            err_d   = ovf_d;
            state_d = ST_IDLE;
          end else begin
            err_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= ST_IDLE;
      cs_prev_q <= 1'b1;
      count_q   <= ZERO_IDX;
      ovf_q     <= 1'b0;
      bank_q    <= 1'b0;
      addr_q    <= {(PIX_ADDR_W+1){1'b0}};
      data_q    <= 8'd0;
      we_q      <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      fcnt_q    <= 16'd0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cs_prev_q <= chip_sel_in;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      bank_q    <= bank_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      we_q      <= we_d;
      done_q    <= done_d;
      err_q     <= err_d;
      fcnt_q    <= fcnt_d;
      busy_q    <= (state_d != ST_IDLE);
    end
  end

  assign bram_addr_out   = addr_q;
  assign bram_data_out   = data_q;
  assign bram_we_out     = we_q;
  assign read_bank_out   = bank_q;
  assign frame_done_out  = done_q;
  assign frame_error_out = err_q;
  assign frame_count_out = fcnt_q;
  assign busy_out        = busy_q;

endmodule

// File: tb/tb_spi_frame_writer.sv
// Bench for spi_frame_writer on an 8-pixel frame: directed and random frames
// checked against a frame-level model of expected writes, pulses and bank state.
module tb_spi_frame_writer;

  localparam int FS = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  pixel = 8'd0;
  logic        pv = 1'b0;
  logic        cs = 1'b1;
  logic [3:0]  addr;
  logic [7:0]  data;
  logic        we, bank, done, err, busy;
  logic [15:0] fcnt;

  int checks = 0;
  int errors = 0;
  int n_we = 0;
  int n_done = 0;
  int n_err = 0;
  bit exp_bank = 1'b0;
  int exp_cnt = 0;

  spi_frame_writer #(.H_PIXELS(4), .V_PIXELS(2)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .pixel_in(pixel), .pixel_valid_in(pv),
    .chip_sel_in(cs), .bram_addr_out(addr), .bram_data_out(data), .bram_we_out(we),
    .read_bank_out(bank), .frame_done_out(done), .frame_error_out(err),
    .frame_count_out(fcnt), .busy_out(busy)
  );

  always #5 clk = ~clk;

  // Pulse counters used to check totals per frame.
  always @(negedge clk) begin
    if (we)   n_we++;
    if (done) n_done++;
    if (err)  n_err++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_addr", 32'(addr), 0);
    chk("rst_data", 32'(data), 0);
    chk("rst_we", 32'(we), 0);
    chk("rst_bank", 32'(bank), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_fcnt", 32'(fcnt), 0);
    chk("rst_busy", 32'(busy), 0);
  endtask

  // One frame of n pixels; base<0 means random data; coinc raises CS with the last pixel.
  task automatic run_frame(input int n, input bit coinc, input int base);
    int we0, d0, e0, exp_addr;
    logic [7:0] px;
    we0 = n_we; d0 = n_done; e0 = n_err;
    @(negedge clk); cs = 1'b0;
    @(negedge clk); chk("busy_start", 32'(busy), 1);
    for (int i = 0; i < n; i++) begin
      px = (base >= 0) ? 8'(base + i) : 8'($urandom);
      pixel = px; pv = 1'b1;
      if (coinc && i == n - 1) cs = 1'b1;
      @(negedge clk); pv = 1'b0;
      exp_addr = (exp_bank ? 0 : FS) + i;
      chk("we", 32'(we), 32'(i < FS));
      chk("done", 32'(done), 32'(i == FS - 1));
      if (i < FS) begin
        chk("addr", 32'(addr), exp_addr);
        chk("data", 32'(data), 32'(px));
      end
      if (coinc && i == n - 1) begin
        chk("err_coinc", 32'(err), 32'(n != FS));
      end else begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end
    if (!coinc) begin
      cs = 1'b1;
      @(negedge clk);
      chk("err_rise", 32'(err), 32'(n != FS));
      chk("done_rise", 32'(done), 0);
    end
    if (n >= FS) begin
      exp_bank = ~exp_bank;
      exp_cnt++;
    end
    @(negedge clk);
    chk("busy_end", 32'(busy), 0);
    chk("read_bank", 32'(bank), 32'(exp_bank));
    chk("frame_count", 32'(fcnt), exp_cnt);
    chk("n_writes", n_we - we0, (n < FS) ? n : FS);
    chk("n_done", n_done - d0, 32'(n >= FS));
    chk("n_err", n_err - e0, 32'(n != FS));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_reset_vals();
    rst_n = 1'b1;
    @(negedge clk);

    run_frame(8, 1'b0, 'h10);
    run_frame(8, 1'b0, 'h20);
    run_frame(5, 1'b0, -1);
    run_frame(10, 1'b0, -1);
    run_frame(8, 1'b1, -1);
    for (int k = 0; k < 8; k++) begin
      run_frame($urandom_range(1, 12), 1'($urandom_range(0, 1)), -1);
    end

    if (!exp_bank) run_frame(8, 1'b0, -1);
    @(negedge clk); cs = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); pixel = 8'($urandom) | 8'h01; pv = 1'b1;
      @(negedge clk); pv = 1'b0;
    end
    chk("pre_rst_bank", 32'(bank), 1);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals();
    exp_bank = 1'b0;
    exp_cnt = 0;
    repeat (2) @(negedge clk);
    cs = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    run_frame(8, 1'b0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_frame_writer.md
Name: spi_frame_writer

Overview:
Consumes the byte stream from the SPI receive stage, which delivers one 8-bit pixel per valid pulse while chip select is low. It frames the pixels using the chip-select edges and writes them into a double-buffered frame BRAM. When a full frame has been written, it swaps banks so the display/depth logic always reads a complete frame. It also flags short or overlong frames.

Parameters:
H_PIXELS, 320, pixels per line
V_PIXELS, 180, lines per frame
FRAME_SIZE, H_PIXELS*V_PIXELS, pixels per frame (derived localparam)
PIX_ADDR_W, $clog2(FRAME_SIZE), in-bank address width (derived localparam)

Ports:
clk_in  input  1  system clock (100 MHz)
rst_n_in  input  1  asynchronous active-low reset
pixel_in  input  8  pixel byte from the SPI receiver
pixel_valid_in  input  1  single-cycle strobe; pixel_in is valid this cycle
chip_sel_in  input  1  SPI CS (low = frame in progress), already synchronous to clk_in
bram_addr_out  output  PIX_ADDR_W+1  write address, {write_bank, pixel_index}
bram_data_out  output  8  write data
bram_we_out  output  1  write enable
read_bank_out  output  1  bank holding the last complete frame
frame_done_out  output  1  one-cycle pulse when a full frame has been written
frame_error_out  output  1  one-cycle pulse when a frame is short or overlong
frame_count_out  output  16  count of completed frames, wraps at 0xFFFF->0
busy_out  output  1  high in RECV or DRAIN

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low (rst_n_in).
- Reset values: all outputs 0. read_bank_out=0, so the write bank is 1. Internal cs_prev=1, state=IDLE, pixel count=0, overflow flag=0.
- Edge detection uses cs_prev, a register of chip_sel_in.
  - fall = cs_prev & ~chip_sel_in.
  - rise = ~cs_prev & chip_sel_in.
- Write bank is always ~read_bank_out.
- IDLE state:
  - pixel_valid_in is ignored.
  - On fall: count<=0, overflow<=0, go to RECV.
- RECV state, on pixel_valid_in:
  - Registered write with 1-cycle latency: bram_we_out=1, bram_data_out=pixel_in, bram_addr_out={~read_bank_out, count}.
  - If count<FRAME_SIZE-1: count++.
  - If count==FRAME_SIZE-1: this is the last pixel.
    - Next cycle: frame_done_out=1, read_bank_out toggles, frame_count_out++.
    - State goes to DRAIN.
- Pixel and edge in the same cycle: pixel_valid_in is processed first, then rise is evaluated.
  - A last pixel coincident with rise gives done with no error, and the state goes to IDLE, not DRAIN.
- rise in RECV before the last pixel (short frame):
  - frame_error_out pulses, there is no bank swap, the state goes to IDLE.
  - Partially written data stays in the write bank and is overwritten by the next frame.
- DRAIN state:
  - pixel_valid_in produces no write and sets overflow.
  - On rise: if overflow, pulse frame_error_out; go to IDLE.
  - A frame that was already reported done stays done; its bank swap is not undone.
- fall while in RECV or DRAIN (CS glitch; requires CS high for one sample): treated as a new frame. count<=0, overflow<=0, go to RECV. No done or error pulse.
- bram_we_out, frame_done_out and frame_error_out are single-cycle pulses and are 0 otherwise.
  - bram_addr_out and bram_data_out hold their last value when not writing.
- busy_out = (state != IDLE), registered.
- Async reset mid-frame: everything returns to reset values immediately. The partial frame is discarded, and read_bank_out returns to 0 even if it was 1.
- Throughput: one pixel per cycle is sustained. The upstream stage delivers at most one pixel every few cycles, and no stall or backpressure exists.

Test Plan:
(Run with H_PIXELS=4, V_PIXELS=2, FRAME_SIZE=8.)
1. Reset, then CS low and 8 pixels 0x10..0x17, then CS high.
   - Required: writes at addr 8..15 with data 0x10..0x17.
   - Required: frame_done_out pulses once, 1 cycle after the 8th valid.
   - Required: read_bank_out=1, frame_count_out=1, no error.
2. Second frame 0x20..0x27.
   - Required: writes at addr 0..7; read_bank_out returns to 0; frame_count_out=2.
3. CS low, 5 pixels, CS high.
   - Required: 5 writes, frame_error_out pulses on the CS rise.
   - Required: read_bank_out and frame_count_out unchanged, state IDLE.
4. CS low, 10 pixels, CS high.
   - Required: exactly 8 writes and frame_done_out once.
   - Required: pixels 9 and 10 are not written; frame_error_out pulses on the CS rise.
5. 8th pixel_valid_in in the same cycle CS rises.
   - Required: the 8th pixel is written, frame_done_out=1, frame_error_out=0, state IDLE.
6. rst_n_in asserted low after 3 pixels of a frame.
   - Required: outputs 0 immediately, read_bank_out=0.
   - Required: the next full frame writes to addr 8..15.
